// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sync_debounce
//  Description : Multi-channel input conditioner for push-button and switch
//                inputs. Each channel runs a SYNC_STAGES-deep flip-flop
//                synchroniser, then a saturating debounce counter advanced by
//                sample_tick, then registered rise/fall edge pulses.
//
//  Parameters  : WIDTH           - number of independent channels
//                SYNC_STAGES     - synchroniser depth, must be >= 2
//                DEBOUNCE_CYCLES - consecutive qualified samples needed to
//                                  accept a new value, must be >= 1
//
//  Ports       : clk         in   system clock, rising edge
//                rst         in   asynchronous active-high reset
//                sample_tick in   debounce counter advance enable
//                din         in   [WIDTH] raw asynchronous inputs
//                level       out  [WIDTH] debounced stable value
//                rise        out  [WIDTH] one-cycle pulse on level 0->1
//                fall        out  [WIDTH] one-cycle pulse on level 1->0
//                toggle      out  [WIDTH] flips on every rise pulse when built
//                                 with SYNC_DEBOUNCE_TOGGLE_EN, else tied 0
//
//  Option      : `define SYNC_DEBOUNCE_TOGGLE_EN to build the toggle flops.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_debounce #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_tick,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] toggle
);

    // Counter wide enough to hold DEBOUNCE_CYCLES; it is cleared on the
    // accepting edge instead of actually reaching that value, so the
    // acceptance test looks for DEBOUNCE_CYCLES-1 plus a qualifying tick.
    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_CNT_W-1:0]     r_cnt;
        logic                   r_level;
        logic                   r_rise;
        logic                   r_fall;
        logic                   w_sync;
        logic                   w_differs;
        logic                   w_accept;

        assign w_sync    = r_sync[SYNC_STAGES-1];
        assign w_differs = w_sync ^ r_level;
        // Last qualifying sample of an uninterrupted run of differing samples.
        assign w_accept  = w_differs && sample_tick && (r_cnt == c_CNT_LAST);

        // Shift chain: bit 0 captures the pin, the MSB is the synchronised value.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], din[i]};
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                // Pulses are derived from the pre-update level so they line up
                // with the edge that changes level and last one cycle.
                r_rise <= w_accept && !r_level;
                r_fall <= w_accept &&  r_level;

                // A sample matching the current level discards any partial
                // count regardless of sample_tick (bounce rejection).
                if (!w_differs || w_accept) begin
                    r_cnt <= '0;
                end else if (sample_tick) begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end

                if (w_accept) begin
                    r_level <= ~r_level;
                end
            end
        end

        assign level[i] = r_level;
        assign rise[i]  = r_rise;
        assign fall[i]  = r_fall;

`ifdef SYNC_DEBOUNCE_TOGGLE_EN
        begin : g_toggle
            logic r_toggle;

            // Keyed off the registered rise pulse, so toggle trails level by
            // one cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_toggle <= 1'b0;
                end else if (r_rise) begin
                    r_toggle <= ~r_toggle;
                end
            end

            assign toggle[i] = r_toggle;
        end
`else
        begin : g_no_toggle
            assign toggle[i] = 1'b0;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_debounce
//  Description : Self-checking bench for sync_debounce with WIDTH=2,
//                SYNC_STAGES=2, DEBOUNCE_CYCLES=4. Expected output words
//                {level, rise, fall, toggle} are queued when each stimulus
//                phase starts and popped/compared once per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_debounce;

    localparam int c_W = 2;

    logic           clk;
    logic           clk_en;
    logic           rst;
    logic           sample_tick;
    logic [c_W-1:0] din;
    logic [c_W-1:0] level;
    logic [c_W-1:0] rise;
    logic [c_W-1:0] fall;
    logic [c_W-1:0] toggle;

    sync_debounce #(
        .WIDTH           (c_W),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .din         (din),
        .level       (level),
        .rise        (rise),
        .fall        (fall),
        .toggle      (toggle)
    );

    // Clock can be held still for the asynchronous reset check.
    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] v;   // {level, rise, fall, toggle}
    } exp_t;

    exp_t           exp_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [c_W-1:0] cur_lv   = '0;   // expected debounced level
    logic [c_W-1:0] cur_tog  = '0;   // expected toggle state if the option is built

    function automatic logic [c_W-1:0] tg(input logic [c_W-1:0] t);
`ifdef SYNC_DEBOUNCE_TOGGLE_EN
        return t;
`else
        return '0;
`endif
    endfunction

    task automatic push(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic check_next();
        exp_t       e;
        logic [7:0] obs;
        obs = {level, rise, fall, toggle};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %b required an entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed {lv,ri,fa,tg}=%b required %b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue n per-edge expectations for a phase where channels in rm rise
    // and channels in fm fall on edge k (k > n means no change expected).
    task automatic expect_phase(input string tag, input int n, input int k,
                                input logic [c_W-1:0] rm, input logic [c_W-1:0] fm);
        logic [c_W-1:0] lv, r, f, t;
        for (int e = 1; e <= n; e++) begin
            lv = (e < k)  ? cur_lv : (cur_lv ^ (rm | fm));
            r  = (e == k) ? rm : '0;
            f  = (e == k) ? fm : '0;
            t  = (e <= k) ? tg(cur_tog) : tg(cur_tog ^ rm);
            push($sformatf("%s_e%0d", tag, e), {lv, r, f, t});
        end
        if (k <= n) begin
            cur_lv  = cur_lv ^ (rm | fm);
            cur_tog = cur_tog ^ rm;
        end
    endtask

    // Clock n edges with din held; gated gives one tick every third edge.
    task automatic drive_and_check(input int n, input bit gated);
        for (int e = 1; e <= n; e++) begin
            sample_tick = gated ? ((e % 3) == 0) : 1'b1;
            step();
            check_next();
        end
        sample_tick = 1'b1;
    endtask

    initial begin
        clk_en      = 1'b0;
        rst         = 1'b0;
        sample_tick = 1'b1;
        din         = '0;

        // Asynchronous reset with the clock stopped.
        #1;
        din = 2'b11;
        rst = 1'b1;
        #2;
        push("rst_async", 8'h00);
        check_next();

        clk_en = 1'b1;
        for (int e = 0; e < 2; e++) begin
            step();
            push("rst_held", 8'h00);
            check_next();
        end
        rst = 1'b0;
        step();
        push("rst_release", 8'h00);
        check_next();

        // Let the synchroniser drain back to 0 without disturbing level.
        din = 2'b00;
        expect_phase("settle", 8, 99, 2'b00, 2'b00);
        drive_and_check(8, 1'b0);

        // Clean press on channel 0: level on the 6th edge.
        din = 2'b01;
        expect_phase("press", 8, 6, 2'b01, 2'b00);
        drive_and_check(8, 1'b0);

        din = 2'b00;
        expect_phase("release", 8, 6, 2'b00, 2'b01);
        drive_and_check(8, 1'b0);

        // Bounce: 3 synchronised high samples, 1 low, then steady high.
        expect_phase("bounce", 12, 10, 2'b01, 2'b00);
        for (int e = 1; e <= 12; e++) begin
            if (e == 1) din = 2'b01;
            if (e == 4) din = 2'b00;
            if (e == 5) din = 2'b01;
            sample_tick = 1'b1;
            step();
            check_next();
        end

        din = 2'b00;
        expect_phase("release2", 8, 6, 2'b00, 2'b01);
        drive_and_check(8, 1'b0);

        // Bring channel 1 high, then drop it with a 1-in-3 sample tick.
        din = 2'b10;
        expect_phase("ch1_press", 8, 6, 2'b10, 2'b00);
        drive_and_check(8, 1'b0);

        din = 2'b00;
        expect_phase("tick_gate", 15, 12, 2'b00, 2'b10);
        drive_and_check(15, 1'b1);

        // Asynchronous reset while channel 0's counter holds 3.
        din = 2'b01;
        expect_phase("pre_rst", 5, 99, 2'b00, 2'b00);
        drive_and_check(5, 1'b0);
        rst = 1'b1;
        #2;
        cur_lv  = '0;
        cur_tog = '0;
        push("rst_midcount", 8'h00);
        check_next();
        for (int e = 0; e < 2; e++) begin
            step();
            push("rst_mid_held", 8'h00);
            check_next();
        end
        rst = 1'b0;
        expect_phase("post_rst", 8, 6, 2'b01, 2'b00);
        drive_and_check(8, 1'b0);

        // Simultaneous opposite transitions on both channels.
        din = 2'b10;
        expect_phase("swap", 8, 6, 2'b10, 2'b01);
        drive_and_check(8, 1'b0);

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Multi-channel input conditioner for the stopwatch's push-button and switch inputs.
- Per channel: SYNC_STAGES-deep flip-flop synchroniser, then a saturating debounce counter gated by a sample tick, then registered rising- and falling-edge pulse outputs.
- Sits between the board pins and the stopwatch control FSM.
- Replaces the single ad-hoc flip-flop per input with one parametrised block.

Parameters:
- WIDTH, 4: number of independent input channels.
- SYNC_STAGES, 2: synchroniser depth in flip-flops; must be at least 2.
- DEBOUNCE_CYCLES, 16: consecutive qualified samples of a new value needed to accept it; must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sample_tick  input  1  debounce-counter advance enable; tie high to count every clock.
- din  input  WIDTH  raw asynchronous inputs, one bit per channel.
- level  output  WIDTH  debounced stable value per channel.
- rise  output  WIDTH  one-cycle pulse when level goes 0->1.
- fall  output  WIDTH  one-cycle pulse when level goes 1->0.
- toggle  output  WIDTH  per-channel toggle state (see Optional Feature).

Behaviour:
- Reset: rst=1 asynchronously clears, with no clock edge needed:
  - all synchroniser flops, debounce counters, level, rise, fall and toggle go to 0;
  - state holds at 0 for as long as rst=1.
  - First update is on the first rising clk edge after rst deasserts.
- Synchroniser:
  - din[i] passes through SYNC_STAGES flops; the last stage is sync[i].
  - sync[i] reflects din[i] exactly SYNC_STAGES edges after din[i] changes.
- Debounce counter:
  - Width is clog2(DEBOUNCE_CYCLES+1); one counter per channel.
  - If sync[i]==level[i]: counter clears to 0 on the next edge, regardless of sample_tick.
  - If sync[i]!=level[i] and sample_tick=1: counter increments.
  - If sync[i]!=level[i] and sample_tick=0: counter holds.
  - On the edge where the counter would reach DEBOUNCE_CYCLES: level[i] inverts and the counter clears to 0.
  - Any sample where sync[i] returns to level[i] before acceptance discards the partial count (bounce rejection).
  - The counter never exceeds DEBOUNCE_CYCLES and never wraps.
- Latency:
  - With sample_tick held at 1 and a clean din step, level changes exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the step.
  - With sample_tick pulsed, the debounce part takes DEBOUNCE_CYCLES qualifying ticks after sync changes.
- Edge pulses:
  - rise[i] and fall[i] are registered; they assert on the same edge that level[i] updates and deassert on the following edge.
  - They are never both high, and never high for two consecutive cycles on one channel.
  - Minimum spacing between rise and fall on one channel is DEBOUNCE_CYCLES ticks.
- Channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses.
- Reset mid-count: the partial count is lost and, after release, a full latency is required again.

Optional Feature:
- Macro: SYNC_DEBOUNCE_TOGGLE_EN.
- Defined:
  - toggle[i] is a register that inverts on every edge where rise[i] is asserted (press-to-start/press-to-stop).
  - toggle changes on the edge after level/rise update, so it lags level by one cycle.
  - Reset value 0.
- Undefined: toggle is driven constant 0 with no flops inferred; the port stays present so the interface is identical in both builds.

Test Plan:
- All tests use WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted.
- Reset: rst=1 with clk stopped and din=2'b11 -> level, rise, fall, toggle all 0 immediately; still 0 one edge after release.
- Clean press: sample_tick=1, din[0] 0->1 held -> level[0]=1 on the 6th edge after the change; rise[0]=1 for exactly that one cycle; fall=0 and channel 1 unchanged throughout.
- Bounce rejection: din[0] high 3 cycles (post-sync), low 1 cycle, then high -> no change on the first burst; level[0]=1 only after 4 further consecutive qualified cycles; exactly one rise pulse.
- Tick gating: sample_tick high one cycle in three, din[1] 1->0 from level 1 -> level[1] falls only after the 4th tick following sync change; one fall[1] pulse; counter holds between ticks.
- Async reset mid-count: assert rst while the channel-0 counter=3 -> counter and outputs cleared without a clock edge; after release the same held input needs the full 6 edges again.
- Toggle (macro defined): two separate debounced presses on din[0] -> toggle[0] goes 0->1 one cycle after the first rise, 1->0 one cycle after the second. With the macro undefined, toggle stays 2'b00.
